f_inv_priority_decoder: RTL and testbench

//  Inverse of the mantissa leading-zero encoder: takes a 5-bit leading-zero count k and rebuilds
//  the 23-bit mantissa position pattern it stands for. Output is a one-hot leading-one vector plus
//  a mask of the don't-care bits below it.

---
 rtl/f_inv_priority_decoder_if.sv | 31 +++
 rtl/f_inv_priority_decoder.sv | 110 +++++++++++
 tb/tb_f_inv_priority_decoder.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/f_inv_priority_decoder_if.sv
// Valid/ready bundle for the inverse leading-zero decoder.
// The upstream side drives the index and the downstream side drives out_ready.
// Both sides use the same interface instance.
interface f_inv_priority_decoder_if #(
  parameter int unsigned MW    = 23,
  parameter int unsigned CNT_W = 8
) ();
  localparam int unsigned IW = 5;

  logic             in_valid;
  logic             in_ready;
  logic [IW-1:0]    in_idx;
  logic             out_valid;
  logic             out_ready;
  logic [MW-1:0]    out_onehot;
  logic [MW-1:0]    out_mask;
  logic             out_err;
  logic [CNT_W-1:0] err_cnt;

  // Environment side: produces indices and consumes decoded results
  modport master (
    output in_valid, in_idx, out_ready,
    input  in_ready, out_valid, out_onehot, out_mask, out_err, err_cnt
  );

  // Decoder side
  modport slave (
    input  in_valid, in_idx, out_ready,
    output in_ready, out_valid, out_onehot, out_mask, out_err, err_cnt
  );
endinterface

// File: rtl/f_inv_priority_decoder.sv
// Inverse of the mantissa leading-zero encoder.
// A 5-bit leading-zero count k is turned into a one-hot leading-one vector and a mask
// that covers the don't-care bits below that leading one.
// The block is a 2-stage valid/ready pipeline with full throughput.
// It also keeps a saturating count of out-of-range indices.
// MW must be at most 31, so that the index range 0..MW fits in the 5-bit index.
module f_inv_priority_decoder #(
  parameter int unsigned MW    = 23,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  f_inv_priority_decoder_if.slave bus
);

  localparam int unsigned      IW      = 5;
  localparam logic [IW-1:0]    MW_IDX  = IW'(MW);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Stage 1: registered index and range flag
  logic             s1_valid_q;
  logic [IW-1:0]    s1_idx_q;
  logic             s1_err_q;

  // Stage 2: registered decoded vectors (these are the outputs)
  logic             out_valid_q;
  logic [MW-1:0]    onehot_q;
  logic [MW-1:0]    mask_q;
  logic             err_q;
  logic [CNT_W-1:0] err_cnt_q;

  // Handshake and decode helpers
  logic             s2_load_c;
  logic             s1_load_c;
  logic             in_fire_c;
  logic             idx_oor_c;
  int               pos_c;
  logic [MW-1:0]    onehot_c;
  logic [MW-1:0]    mask_c;

  // Stage 2 can take new data when it is empty or its current item leaves this cycle
  assign s2_load_c = !out_valid_q || bus.out_ready;
  // Stage 1 can take new data when it is empty or its item advances into stage 2
  assign s1_load_c = !s1_valid_q || s2_load_c;
  assign in_fire_c = bus.in_valid && s1_load_c;
  // k == MW is the legal all-zero mantissa case; only indices above MW are errors
  assign idx_oor_c = bus.in_idx > MW_IDX;

  // Stage 1 register: capture the index and its range check on each input transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_err_q   <= 1'b0;
    end else if (s1_load_c) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_idx_q <= bus.in_idx;
        s1_err_q <= idx_oor_c;
      end
    end
  end

  // Decode the stage-1 index into the leading-one position and the mask below it.
  // When k >= MW, pos_c is negative, so no bit matches and both vectors stay zero.
  always_comb begin
    onehot_c = '0;
    mask_c   = '0;
    pos_c    = int'(MW) - 1 - int'(s1_idx_q);
    for (int i = 0; i < int'(MW); i++) begin
      onehot_c[i] = (i == pos_c);
      mask_c[i]   = (i < pos_c);
    end
  end

  // Stage 2 register: the outputs, which hold steady while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      onehot_q    <= '0;
      mask_q      <= '0;
      err_q       <= 1'b0;
    end else if (s2_load_c) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        onehot_q <= onehot_c;
        mask_q   <= mask_c;
        err_q    <= s1_err_q;
      end
    end
  end

  // Saturating count of accepted out-of-range indices; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (in_fire_c && idx_oor_c && (err_cnt_q != CNT_MAX)) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  // in_ready is the only combinational path; it follows out_ready through s2_load_c
  assign bus.in_ready   = s1_load_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_onehot = onehot_q;
  assign bus.out_mask   = mask_q;
  assign bus.out_err    = err_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_f_inv_priority_decoder.sv
// Scoreboard bench for f_inv_priority_decoder.
// The driver pushes the expected result whenever an input transfer happens.
// The monitor pops and compares whenever an output transfer happens.
module tb_f_inv_priority_decoder;
  localparam int unsigned MW    = 23;
  localparam int unsigned CNT_W = 8;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  f_inv_priority_decoder_if #(.MW(MW), .CNT_W(CNT_W)) bus ();

  f_inv_priority_decoder #(.MW(MW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]    idx;
    logic [MW-1:0] oh;
    logic [MW-1:0] mk;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   cyc       = 0;
  int   err_model = 0;
  bit   chk_lat   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference leading-zero encoder, used for the round-trip invariant
  function automatic int lzc(input logic [MW-1:0] v);
    for (int i = int'(MW) - 1; i >= 0; i--) begin
      if (v[i]) return int'(MW) - 1 - i;
    end
    return int'(MW);
  endfunction

  // Decode table used for the streamed and random traffic
  function automatic exp_t model(input logic [4:0] k);
    exp_t e;
    e.idx = k;
    e.oh  = '0;
    e.mk  = '0;
    e.err = (int'(k) > int'(MW));
    e.cyc = 0;
    if (int'(k) < int'(MW)) begin
      e.oh = MW'(1) << (int'(MW) - 1 - int'(k));
      e.mk = e.oh - MW'(1);
    end
    return e;
  endfunction

  // Record one input transfer: the expected result and the error-counter model
  task automatic push(input exp_t e);
    e.cyc = cyc;
    sb.push_back(e);
    if (e.err && err_model < 255) err_model++;
  endtask

  // Drive one index until it is accepted; called and returns at posedge+1
  task automatic send(input logic [4:0] k, input logic [MW-1:0] oh,
                      input logic [MW-1:0] mk, input logic err);
    exp_t e;
    bit acc;
    acc = 1'b0;
    e.idx = k; e.oh = oh; e.mk = mk; e.err = err; e.cyc = 0;
    bus.in_valid = 1'b1;
    bus.in_idx   = k;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push(e);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: k=%0d never accepted", k);
    end
  endtask

  task automatic send_m(input logic [4:0] k);
    exp_t e;
    e = model(k);
    send(k, e.oh, e.mk, e.err);
  endtask

  // Wait until every expected result has been seen, then realign to posedge+1
  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results still outstanding", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each output transfer and check that a stalled output holds still
  exp_t          m_e;
  logic [MW-1:0] h_oh;
  logic [MW-1:0] h_mk;
  logic          h_err;
  bit            h_stall = 1'b0;
  logic [MW-1:0] fill;

  always @(negedge clk) begin
    #1;
    if (rst_n && bus.out_valid) begin
      if (bus.out_ready) begin
        h_stall = 1'b0;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_output: got onehot 0x%0h with nothing outstanding", bus.out_onehot);
        end else begin
          m_e = sb.pop_front();
          chk("onehot", 32'(bus.out_onehot), 32'(m_e.oh));
          chk("mask", 32'(bus.out_mask), 32'(m_e.mk));
          chk("err", 32'(bus.out_err), 32'(m_e.err));
          if (chk_lat) chk("latency", 32'(cyc - m_e.cyc), 32'd2);
          if (int'(m_e.idx) <= int'(MW)) begin
            fill = MW'($urandom);
            chk("roundtrip", 32'(lzc(bus.out_onehot | (bus.out_mask & fill))), 32'(m_e.idx));
          end
        end
      end else begin
        if (h_stall) begin
          chk("hold_onehot", 32'(bus.out_onehot), 32'(h_oh));
          chk("hold_mask", 32'(bus.out_mask), 32'(h_mk));
          chk("hold_err", 32'(bus.out_err), 32'(h_err));
        end
        h_oh    = bus.out_onehot;
        h_mk    = bus.out_mask;
        h_err   = bus.out_err;
        h_stall = 1'b1;
      end
    end else begin
      h_stall = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_idx   = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_onehot", 32'(bus.out_onehot), 32'd0);
    chk("rst_mask", 32'(bus.out_mask), 32'd0);
    chk("rst_err", 32'(bus.out_err), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(bus.in_ready), 32'd1);

    // Directed decode table, back to back, with hand-computed results
    bus.out_ready = 1'b1;
    chk_lat = 1'b1;
    send(5'd0,  23'h400000, 23'h3FFFFF, 1'b0);
    send(5'd1,  23'h200000, 23'h1FFFFF, 1'b0);
    send(5'd21, 23'h000002, 23'h000001, 1'b0);
    send(5'd22, 23'h000001, 23'h000000, 1'b0);
    send(5'd23, 23'h000000, 23'h000000, 1'b0);
    bus.in_valid = 1'b0;
    drain();
    chk_lat = 1'b0;

    // Out-of-range indices and error counter saturation
    send(5'd24, '0, '0, 1'b1);
    send(5'd31, '0, '0, 1'b1);
    send(5'd31, '0, '0, 1'b1);
    bus.in_valid = 1'b0;
    drain();
    chk("err_cnt_3", 32'(bus.err_cnt), 32'd3);
    for (int i = 0; i < 300; i++) send(5'd31, '0, '0, 1'b1);
    bus.in_valid = 1'b0;
    drain();
    chk("err_cnt_sat", 32'(bus.err_cnt), 32'd255);

    // Stream 0..23 with a 5-cycle downstream stall in the middle
    fork
      begin
        for (int k = 0; k < 24; k++) send_m(5'(k));
        bus.in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          #2;
          if (s == 2) begin
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_occupancy", 32'(sb.size()), 32'd2);
          end
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Random valid/ready traffic
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
      begin
        exp_t e;
        for (int i = 0; i < 10000; i++) begin
          bus.in_valid = 1'($urandom_range(0, 1));
          bus.in_idx   = 5'($urandom_range(0, 31));
          @(negedge clk);
          if (bus.in_valid && bus.in_ready) begin
            e = model(bus.in_idx);
            push(e);
          end
          @(posedge clk);
          #1;
        end
      end
    join
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    chk("err_cnt_model", 32'(bus.err_cnt), 32'(err_model));

    // Asynchronous reset with two items in flight
    bus.out_ready = 1'b0;
    send_m(5'd3);
    send_m(5'd4);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #3;
    chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    err_model = 0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_onehot", 32'(bus.out_onehot), 32'd0);
    chk("arst_mask", 32'(bus.out_mask), 32'd0);
    chk("arst_err", 32'(bus.out_err), 32'd0);
    chk("arst_err_cnt", 32'(bus.err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_arst", 32'(bus.in_ready), 32'd1);
    chk_lat = 1'b1;
    send(5'd5, 23'h020000, 23'h01FFFF, 1'b0);
    bus.in_valid = 1'b0;
    drain();
    chk("err_cnt_after_arst", 32'(bus.err_cnt), 32'd0);

    // Full-throughput streaming: one result per cycle at latency 2
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      exp_t e;
      bus.in_idx = 5'(i % 24);
      @(negedge clk);
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      if (bus.in_ready) begin
        e = model(bus.in_idx);
        push(e);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain();
    chk_lat = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
